seq_multiplier64: RTL and testbench

//  Multi-cycle shift-add multiplier for the LEGv8 MUL path (and UMULH, when enabled).
//  - Consumes the two register-file read ports: ReadData1 -> A, ReadData2 -> B.
//  - Produces a 64-bit product plus a destination index and write strobe.
//  - Those outputs drive the register file's WriteData, WriteRegister and RegWrite.
//  - Control logic must hold the pipeline while busy is high.

---
 rtl/seq_multiplier64.sv | 101 ++++++++++
 tb/tb_seq_multiplier64.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier64.sv
// Multi-cycle shift-add multiplier for the LEGv8 MUL path (one partial product per clock).
// Define HIGH_PRODUCT_EN to add the resultHi port carrying the upper product half for UMULH.
module seq_multiplier64 #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       destReg,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef HIGH_PRODUCT_EN
    output logic [WIDTH-1:0] resultHi,
`endif
    output logic [4:0]       resultReg,
    output logic             RegWrite
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT              state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] nextAcc;
    logic               lastIter;

    // One shift-add step; the add keeps its carry so the shifted accumulator never loses a bit.
    always_comb begin
        addend   = acc[0] ? {1'b0, mcand} : '0;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend;
        nextAcc  = {sum, acc[WIDTH-1:1]};
        lastIter = (cnt == CNT_W'(WIDTH - 1));
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mcand     <= '0;
            acc       <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            RegWrite  <= 1'b0;
            result    <= '0;
            resultReg <= '0;
`ifdef HIGH_PRODUCT_EN
            resultHi  <= '0;
`endif
        end else begin
            done     <= 1'b0;
            RegWrite <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        mcand     <= A;
                        acc       <= {{WIDTH{1'b0}}, B};
                        resultReg <= destReg;
                        cnt       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (cancel) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        acc <= nextAcc;
                        cnt <= cnt + 1'b1;
                        if (lastIter) begin
                            result   <= nextAcc[WIDTH-1:0];
`ifdef HIGH_PRODUCT_EN
                            resultHi <= nextAcc[2*WIDTH-1:WIDTH];
`endif
                            done     <= 1'b1;
                            // XZR writes are dropped but the completion still pulses done.
                            RegWrite <= (resultReg != 5'd31);
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier64.sv
// Directed self-checking bench for seq_multiplier64 using immediate assertions.
module tb_seq_multiplier64;

    logic        clk;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [63:0] A;
    logic [63:0] B;
    logic [4:0]  destReg;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic [4:0]  resultReg;
    logic        RegWrite;
`ifdef HIGH_PRODUCT_EN
    logic [63:0] resultHi;
`endif

    int checks   = 0;
    int failures = 0;

    seq_multiplier64 dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cancel    (cancel),
        .A         (A),
        .B         (B),
        .destReg   (destReg),
        .busy      (busy),
        .done      (done),
        .result    (result),
`ifdef HIGH_PRODUCT_EN
        .resultHi  (resultHi),
`endif
        .resultReg (resultReg),
        .RegWrite  (RegWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulses start for one edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic [4:0] d);
        A       = a;
        B       = b;
        destReg = d;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    // Counts edges until done, bounded; lat=-1 if it never came. Tracks busy dropping early.
    task automatic waitDone(input int bound, output int lat, output logic busyHeld);
        lat      = -1;
        busyHeld = 1'b1;
        for (int i = 1; i <= bound; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) busyHeld = 1'b0;
        end
    endtask

    task automatic watchNoDone(input int cycles, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
    endtask

    int   lat;
    logic busyHeld;
    logic seen;

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        cancel  = 1'b0;
        A       = '0;
        B       = '0;
        destReg = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_result", result, 64'd0);
        checkOutput("reset_resultReg", 64'(resultReg), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] 3*5 -> r4");
        applyStimulus(64'd3, 64'd5, 5'd4);
        checkOutput("t1_busy_after_accept", 64'(busy), 64'd1);
        waitDone(200, lat, busyHeld);
        checkOutput("t1_latency", 64'(lat), 64'd64);
        checkOutput("t1_busy_held", 64'(busyHeld), 64'd1);
        checkOutput("t1_result", result, 64'd15);
        checkOutput("t1_resultReg", 64'(resultReg), 64'd4);
        checkOutput("t1_regwrite", 64'(RegWrite), 64'd1);
        checkOutput("t1_busy_in_done", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("t1_done_pulse_end", 64'(done), 64'd0);
        checkOutput("t1_regwrite_end", 64'(RegWrite), 64'd0);
        checkOutput("t1_idle_busy", 64'(busy), 64'd0);
        checkOutput("t1_result_held", result, 64'd15);

        $display("[TB] all-ones squared");
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7);
        waitDone(200, lat, busyHeld);
        checkOutput("t2_latency", 64'(lat), 64'd64);
        checkOutput("t2_result", result, 64'h1);
`ifdef HIGH_PRODUCT_EN
        checkOutput("t2_resultHi", resultHi, 64'hFFFF_FFFF_FFFF_FFFE);
`endif
        @(posedge clk);
        #1;

        $display("[TB] XZR destination");
        applyStimulus(64'd7, 64'd9, 5'd31);
        waitDone(200, lat, busyHeld);
        checkOutput("t3_done", 64'(done), 64'd1);
        checkOutput("t3_result", result, 64'd63);
        checkOutput("t3_regwrite", 64'(RegWrite), 64'd0);
        checkOutput("t3_resultReg", 64'(resultReg), 64'd31);
        @(posedge clk);
        #1;

        $display("[TB] start while busy");
        applyStimulus(64'd11, 64'd13, 5'd5);
        repeat (10) @(posedge clk);
        #1;
        A       = 64'd2;
        B       = 64'd2;
        destReg = 5'd6;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        waitDone(200, lat, busyHeld);
        checkOutput("t4_latency", 64'(lat), 64'd53);
        checkOutput("t4_busy_held", 64'(busyHeld), 64'd1);
        checkOutput("t4_result", result, 64'd143);
        checkOutput("t4_resultReg", 64'(resultReg), 64'd5);
        watchNoDone(80, seen);
        checkOutput("t4_single_done", 64'(seen), 64'd0);

        $display("[TB] async reset mid-run");
        applyStimulus(64'd100, 64'd3, 5'd8);
        repeat (20) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("t5_reset_busy", 64'(busy), 64'd0);
        checkOutput("t5_reset_done", 64'(done), 64'd0);
        checkOutput("t5_reset_regwrite", 64'(RegWrite), 64'd0);
        checkOutput("t5_reset_result", result, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        watchNoDone(80, seen);
        checkOutput("t5_no_done_after_reset", 64'(seen), 64'd0);

        $display("[TB] cancel mid-run");
        applyStimulus(64'd21, 64'd2, 5'd3);
        waitDone(200, lat, busyHeld);
        checkOutput("t5c_prior_result", result, 64'd42);
        @(posedge clk);
        #1;
        applyStimulus(64'd1000, 64'd1000, 5'd2);
        repeat (29) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        checkOutput("t5c_cancel_idle", 64'(busy), 64'd0);
        watchNoDone(80, seen);
        checkOutput("t5c_no_done", 64'(seen), 64'd0);
        checkOutput("t5c_result_held", result, 64'd42);
        checkOutput("t5c_resultReg", 64'(resultReg), 64'd2);

        $display("[TB] cancel beats start in IDLE");
        A      = 64'd5;
        B      = 64'd5;
        start  = 1'b1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        checkOutput("t5d_stay_idle", 64'(busy), 64'd0);

        $display("[TB] zero operand and back-to-back");
        applyStimulus(64'd0, 64'h1234, 5'd10);
        waitDone(200, lat, busyHeld);
        checkOutput("t6_latency", 64'(lat), 64'd64);
        checkOutput("t6_result", result, 64'd0);
        A       = 64'd6;
        B       = 64'd7;
        destReg = 5'd9;
        start   = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6_start_in_done_ignored", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("t6_b2b_accepted", 64'(busy), 64'd1);
        waitDone(200, lat, busyHeld);
        checkOutput("t6_b2b_latency", 64'(lat), 64'd64);
        checkOutput("t6_b2b_result", result, 64'd42);
        checkOutput("t6_b2b_resultReg", 64'(resultReg), 64'd9);
        checkOutput("t6_b2b_regwrite", 64'(RegWrite), 64'd1);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
